// File: rtl/instruction_pkg.sv
// Shared fetch-path constants, the FIFO entry layout and an address helper.
package instruction_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} fetch entries; flush wins over push and pop.
module fetch_fifo
  import instruction_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  localparam int CW = $clog2(BUF_DEPTH + 1),
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output fetch_entry_t  head
);

  fetch_entry_t  mem [BUF_DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_r] <= din;
  end

  assign count = count_r;
  assign full  = (count_r == CW'(BUF_DEPTH));
  assign empty = (count_r == '0);
  assign head  = mem[rd_ptr_r];

endmodule

// File: rtl/fetch_unit_checker.sv
// Simulation-only invariants of the fetch unit's credit and kill bookkeeping.
module fetch_unit_checker #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          push,
  input logic          pop,
  input logic          full,
  input logic          empty,
  input logic          rvalid,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] kill_cnt
);

  a_no_overflow:     assert property (@(posedge clk) disable iff (reset) (push && full) |-> pop);
  a_pop_nonempty:    assert property (@(posedge clk) disable iff (reset) pop |-> !empty);
  a_out_underflow:   assert property (@(posedge clk) disable iff (reset) rvalid |-> (outstanding != '0));
  a_kill_within_out: assert property (@(posedge clk) disable iff (reset) kill_cnt <= outstanding);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: credit-limited in-order imem requests, response
// FIFO towards execute, and branch redirects that kill wrong-path fetches.
module fetch_unit
  import instruction_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        pc_v_x_i,
  input  logic [31:0] pc_x_i,
  output logic [31:0] pc_o,
  output logic        inst_v_o,
  output logic [31:0] inst_o
);

  localparam int          CW  = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] CAP = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   resp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] kill_cnt_r;

  logic [CW-1:0] count_s;
  logic          full_s;
  logic          empty_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_entry_s;
  logic          pop_s;
  logic          push_s;
  logic          req_s;
  logic          grant_s;
  logic [CW:0]   credit_s;

  // Output, credit and response-acceptance decisions for this cycle.
  always_comb begin
    pop_s        = !empty_s && !halt_i && !pc_v_x_i && !reset;
    credit_s     = {1'b0, outstanding_r} + {1'b0, count_s} - {{CW{1'b0}}, pop_s};
    req_s        = !halt_i && !reset && !pc_v_x_i && (credit_s < CAP);
    grant_s      = req_s && imem_gnt_i;
    push_s       = imem_rvalid_i && (kill_cnt_r == '0) && !pc_v_x_i && !reset;
    push_entry_s = '{pc: resp_pc_r, inst: imem_rdata_i};
  end

  // PC, outstanding-request and wrong-path kill bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= '0;
      kill_cnt_r    <= '0;
    end else begin
      outstanding_r <= outstanding_r + CW'(grant_s) - CW'(imem_rvalid_i);
      if (pc_v_x_i) begin
        // Everything still in flight belongs to the wrong path.
        fetch_pc_r <= word_align(pc_x_i);
        resp_pc_r  <= word_align(pc_x_i);
        kill_cnt_r <= outstanding_r - CW'(imem_rvalid_i);
      end else begin
        if (grant_s) fetch_pc_r <= fetch_pc_r + INST_BYTES;
        if (push_s)  resp_pc_r  <= resp_pc_r + INST_BYTES;
        if (imem_rvalid_i && (kill_cnt_r != '0)) kill_cnt_r <= kill_cnt_r - CW'(1);
      end
    end
  end

  fetch_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (pc_v_x_i),
    .din   (push_entry_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  fetch_unit_checker #(.CW(CW)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .push        (push_s),
    .pop         (pop_s),
    .full        (full_s),
    .empty       (empty_s),
    .rvalid      (imem_rvalid_i),
    .outstanding (outstanding_r),
    .kill_cnt    (kill_cnt_r)
  );

  assign imem_req_o  = req_s;
  assign imem_addr_o = fetch_pc_r;
  assign inst_v_o    = pop_s;
  assign pc_o        = head_s.pc;
  assign inst_o      = head_s.inst;

endmodule
